mem_axi_bridge: RTL and testbench

Downstream neighbour of the cache arbiter: accepts one 512-bit cache-line request at a time (read fill or dirty write-back) on the arbiter's `mem_*` interface and executes it as one 8-beat, 64-bit AXI4 INCR burst. Read beats are assembled into a line and returned as a single-cycle completion. Snoop addresses arriving on the AC channel are forwarded to the arbiter as one-cycle `invalidate_cache` pulses.

---
 rtl/mem_axi_bridge_if.sv | 89 ++++++++
 rtl/mem_axi_bridge.sv | 172 +++++++++++++++++
 tb/tb_mem_axi_bridge.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_axi_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_axi_bridge_if
// Description : Bundle of the arbiter-side line interface, the AXI4 master
//               channels and the AC snoop channel used by mem_axi_bridge.
//               "master" is the bridge view, "slave" is the environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_axi_bridge_if #(
  parameter int ADDR_W = 64,
  parameter int BUS_W  = 64,
  parameter int LINE_W = 512
);
  // Arbiter side
  logic                 mem_req;
  logic                 mem_wr_en;
  logic [ADDR_W-1:0]    mem_address;
  logic [LINE_W-1:0]    mem_data_out;
  logic [LINE_W-1:0]    data_from_mem;
  logic                 mem_data_valid;
  logic                 invalidate_cache;
  logic [ADDR_W-1:0]    invalidate_cache_addr;

  // AXI read address / data
  logic                 m_axi_arvalid;
  logic                 m_axi_arready;
  logic [ADDR_W-1:0]    m_axi_araddr;
  logic [7:0]           m_axi_arlen;
  logic [2:0]           m_axi_arsize;
  logic [1:0]           m_axi_arburst;
  logic                 m_axi_rvalid;
  logic                 m_axi_rready;
  logic [BUS_W-1:0]     m_axi_rdata;

  // AXI write address / data / response
  logic                 m_axi_awvalid;
  logic                 m_axi_awready;
  logic [ADDR_W-1:0]    m_axi_awaddr;
  logic [7:0]           m_axi_awlen;
  logic [2:0]           m_axi_awsize;
  logic [1:0]           m_axi_awburst;
  logic                 m_axi_wvalid;
  logic                 m_axi_wready;
  logic [BUS_W-1:0]     m_axi_wdata;
  logic [BUS_W/8-1:0]   m_axi_wstrb;
  logic                 m_axi_wlast;
  logic                 m_axi_bvalid;
  logic                 m_axi_bready;

  // Snoop address channel
  logic                 ac_valid;
  logic                 ac_ready;
  logic [ADDR_W-1:0]    ac_addr;

  modport master (
    input  mem_req, mem_wr_en, mem_address, mem_data_out,
    output data_from_mem, mem_data_valid, invalidate_cache, invalidate_cache_addr,
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rdata,
    output m_axi_rready,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    input  m_axi_awready,
    output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    input  m_axi_wready,
    input  m_axi_bvalid,
    output m_axi_bready,
    input  ac_valid, ac_addr,
    output ac_ready
  );

  modport slave (
    output mem_req, mem_wr_en, mem_address, mem_data_out,
    input  data_from_mem, mem_data_valid, invalidate_cache, invalidate_cache_addr,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rdata,
    input  m_axi_rready,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    output m_axi_awready,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    output m_axi_wready,
    output m_axi_bvalid,
    input  m_axi_bready,
    output ac_valid, ac_addr,
    input  ac_ready
  );
endinterface
`default_nettype wire

// File: rtl/mem_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mem_axi_bridge
// Description : Executes one cache-line read fill or write-back at a time as
//               a single 8-beat INCR AXI4 burst; forwards AC snoops to the
//               arbiter as one-cycle invalidate pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_axi_bridge #(
  parameter int ADDR_W = 64,
  parameter int BUS_W  = 64,
  parameter int LINE_W = 512
) (
  input  logic             clk,
  input  logic             rst,
  mem_axi_bridge_if.master bus
);
  localparam int BEATS = LINE_W / BUS_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [LINE_W-1:0]   line, line_nxt, rd_line;
  logic [ADDR_W-1:0]   addr, snoop_addr;
  logic                snoop_pulse;
  logic [BUS_W-1:0]    wr_word;
  logic                last_beat;
  logic                arvalid, rready, awvalid, wvalid, wlast, bready, done;

  assign last_beat = (cnt == LAST_BEAT);

  // Lane select: outgoing write beat and the line with the incoming read beat merged in
  always_comb begin
    wr_word  = '0;
    line_nxt = line;
    for (int i = 0; i < BEATS; i++) begin
      if (cnt == CNT_W'(i)) begin
        wr_word                    = line[i*BUS_W +: BUS_W];
        line_nxt[i*BUS_W +: BUS_W] = bus.m_axi_rdata;
      end
    end
  end

  // State register; reset abandons any burst in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and channel controls, decoded from state and beat counter only
  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_req) state_nxt = bus.mem_wr_en ? WR_ADDR : RD_ADDR;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (bus.m_axi_arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (bus.m_axi_rvalid && last_beat) state_nxt = DONE;
      end
      WR_ADDR: begin
        awvalid = 1'b1;
        if (bus.m_axi_awready) state_nxt = WR_DATA;
      end
      WR_DATA: begin
        wvalid = 1'b1;
        wlast  = last_beat;
        if (bus.m_axi_wready && last_beat) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bus.m_axi_bvalid) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, beat counting and read-line assembly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      line    <= '0;
      addr    <= '0;
      rd_line <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_req) begin
            addr <= bus.mem_address & LINE_MASK;
            line <= bus.mem_data_out;
            cnt  <= '0;
          end
        end
        RD_ADDR: if (bus.m_axi_arready) cnt <= '0;
        RD_DATA: begin
          if (bus.m_axi_rvalid) begin
            line <= line_nxt;
            cnt  <= cnt + CNT_W'(1);
            // Publish the completed line so it is visible during DONE
            if (last_beat) rd_line <= line_nxt;
          end
        end
        WR_ADDR: if (bus.m_axi_awready) cnt <= '0;
        WR_DATA: if (bus.m_axi_wready) cnt <= cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Snoop forwarding, independent of the burst FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snoop_pulse <= 1'b0;
      snoop_addr  <= '0;
    end else begin
      snoop_pulse <= bus.ac_valid;
      if (bus.ac_valid) snoop_addr <= bus.ac_addr & LINE_MASK;
    end
  end

  assign bus.data_from_mem         = rd_line;
  assign bus.mem_data_valid        = done;
  assign bus.invalidate_cache      = snoop_pulse;
  assign bus.invalidate_cache_addr = snoop_addr;
  assign bus.ac_ready              = 1'b1;

  assign bus.m_axi_arvalid = arvalid;
  assign bus.m_axi_araddr  = addr;
  assign bus.m_axi_arlen   = 8'(BEATS - 1);
  assign bus.m_axi_arsize  = 3'($clog2(BUS_W / 8));
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_rready  = rready;

  assign bus.m_axi_awvalid = awvalid;
  assign bus.m_axi_awaddr  = addr;
  assign bus.m_axi_awlen   = 8'(BEATS - 1);
  assign bus.m_axi_awsize  = 3'($clog2(BUS_W / 8));
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_wvalid  = wvalid;
  assign bus.m_axi_wdata   = wvalid ? wr_word : '0;
  assign bus.m_axi_wstrb   = '1;
  assign bus.m_axi_wlast   = wlast;
  assign bus.m_axi_bready  = bready;
endmodule
`default_nettype wire

// File: tb/tb_mem_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_axi_bridge
// Description : Self-checking bench for mem_axi_bridge: table of line
//               transactions against a small AXI slave model with read-line
//               and write-beat scoreboards, plus snoop and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_axi_bridge;
  localparam int ADDR_W = 64;
  localparam int BUS_W  = 64;
  localparam int LINE_W = 512;
  localparam int BEATS  = 8;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] base;       // word i of the line = base + i
    int          ar_d;       // address-ready delay in cycles
    int          gap;        // idle cycles between data beats
    int          b_d;        // bvalid delay after last W beat
    int          snoop_at;   // cycle offset of an AC snoop, -1 none
    logic [63:0] snoop_addr;
    int          req2_at;    // cycle offset of a stray mem_req, -1 none
    logic [63:0] exp_addr;
    logic [63:0] exp_snoop;
    int          exp_lat;    // mem_data_valid cycle relative to mem_req
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic [LINE_W-1:0] last_read = '0;
  logic [LINE_W-1:0] rd_q[$];
  logic [BUS_W:0]    w_q[$];
  vec_t vecs[7];

  mem_axi_bridge_if #(.ADDR_W(ADDR_W), .BUS_W(BUS_W), .LINE_W(LINE_W)) bus();

  mem_axi_bridge #(.ADDR_W(ADDR_W), .BUS_W(BUS_W), .LINE_W(LINE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.mem_req       = 1'b0;
    bus.mem_wr_en     = 1'b0;
    bus.mem_address   = '0;
    bus.mem_data_out  = '0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_bvalid  = 1'b0;
    bus.ac_valid      = 1'b0;
    bus.ac_addr       = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_from_mem"}, bus.data_from_mem, 0);
    chk({tag, "_mem_data_valid"}, bus.mem_data_valid, 0);
    chk({tag, "_invalidate"}, bus.invalidate_cache, 0);
    chk({tag, "_inv_addr"}, bus.invalidate_cache_addr, 0);
    chk({tag, "_axi_valids"}, {bus.m_axi_arvalid, bus.m_axi_awvalid, bus.m_axi_wvalid}, 0);
    chk({tag, "_axi_readies"}, {bus.m_axi_rready, bus.m_axi_bready}, 0);
    chk({tag, "_axi_addrs"}, {bus.m_axi_araddr, bus.m_axi_awaddr}, 0);
    chk({tag, "_wdata_wlast"}, {bus.m_axi_wdata, bus.m_axi_wlast}, 0);
  endtask

  // One line transaction driven through an AXI slave model
  task automatic run_txn(input vec_t v);
    int t0, rel, ar_n, aw_n, ar_hs, aw_hs, rbeats, wbeats, rd_t, wr_t, b_n, wviol, mdv;
    bit rd_on, wdone, bdone, done;
    logic [LINE_W-1:0] line_in, exp_line;
    logic [BUS_W:0]    wexp;
    ar_n = 0; aw_n = 0; ar_hs = 0; aw_hs = 0; rbeats = 0; wbeats = 0;
    rd_t = 0; wr_t = 0; b_n = 0; wviol = 0; mdv = 0;
    rd_on = 0; wdone = 0; bdone = 0; done = 0;
    for (int i = 0; i < BEATS; i++) line_in[i*BUS_W +: BUS_W] = v.base + 64'(i);
    if (v.wr) begin
      for (int i = 0; i < BEATS; i++)
        w_q.push_back({1'(i == BEATS - 1), line_in[i*BUS_W +: BUS_W]});
      bus.mem_data_out = line_in;
    end else begin
      rd_q.push_back(line_in);
      bus.mem_data_out = {BEATS{64'hDEAD_BEEF_0BAD_F00D}};
    end
    bus.mem_req     = 1'b1;
    bus.mem_wr_en   = v.wr;
    bus.mem_address = v.addr;
    t0 = cyc;
    tick();
    bus.mem_req      = 1'b0;
    bus.mem_wr_en    = 1'b0;
    bus.mem_address  = '0;
    bus.mem_data_out = '0;
    chk("addr_valid_at_T+1", v.wr ? bus.m_axi_awvalid : bus.m_axi_arvalid, 1);
    chk("addr_at_T+1", v.wr ? bus.m_axi_awaddr : bus.m_axi_araddr, v.exp_addr);
    for (int k = 0; k < 300; k++) begin
      rel = cyc - t0;
      if (done && rel > v.snoop_at + 2) break;
      // Observe this cycle's outputs
      if (bus.mem_data_valid) begin
        mdv++;
        if (!done) begin
          done = 1;
          chk("completion_latency", rel, v.exp_lat);
          if (v.wr) chk("write_keeps_line", bus.data_from_mem, last_read);
          else if (rd_q.size() > 0) begin
            exp_line = rd_q.pop_front();
            chk("read_line", bus.data_from_mem, exp_line);
            last_read = exp_line;
          end
        end
      end
      if (v.snoop_at >= 0 && rel == v.snoop_at + 1) begin
        chk("snoop_pulse", bus.invalidate_cache, 1);
        chk("snoop_addr", bus.invalidate_cache_addr, v.exp_snoop);
      end
      if (v.snoop_at >= 0 && rel == v.snoop_at + 2) chk("snoop_pulse_end", bus.invalidate_cache, 0);
      if (bus.m_axi_wvalid && aw_hs == 0) wviol++;
      // Snoop and stray request stimulus
      bus.ac_valid    = (rel == v.snoop_at);
      bus.ac_addr     = (rel == v.snoop_at) ? v.snoop_addr : 64'h0;
      bus.mem_req     = (rel == v.req2_at);
      bus.mem_address = 64'h9999_0000;
      // B channel (evaluated before W so it starts the cycle after the last beat)
      if (wdone && !bdone) begin
        bus.m_axi_bvalid = (b_n >= v.b_d);
        if (bus.m_axi_bvalid && bus.m_axi_bready) bdone = 1;
        b_n++;
      end else bus.m_axi_bvalid = 1'b0;
      // R channel
      if (rd_on && rbeats < BEATS) begin
        bus.m_axi_rvalid = (rd_t % (v.gap + 1) == 0);
        bus.m_axi_rdata  = bus.m_axi_rvalid ? v.base + 64'(rbeats) : 64'hBAD0_BAD0_BAD0_BAD0;
        if (bus.m_axi_rvalid && bus.m_axi_rready) rbeats++;
        rd_t++;
      end else begin
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
      end
      // AR channel
      if (bus.m_axi_arvalid) begin
        bus.m_axi_arready = (ar_n >= v.ar_d);
        if (bus.m_axi_arready) begin
          ar_hs++;
          rd_on = 1;
          chk("araddr_at_handshake", bus.m_axi_araddr, v.exp_addr);
        end
        ar_n++;
      end else bus.m_axi_arready = 1'b0;
      // AW channel
      if (bus.m_axi_awvalid) begin
        bus.m_axi_awready = (aw_n >= v.ar_d);
        if (bus.m_axi_awready) begin
          aw_hs++;
          chk("awaddr_at_handshake", bus.m_axi_awaddr, v.exp_addr);
        end
        aw_n++;
      end else bus.m_axi_awready = 1'b0;
      // W channel
      if (bus.m_axi_wvalid) begin
        bus.m_axi_wready = (wr_t % (v.gap + 1) == 0);
        if (bus.m_axi_wready) begin
          if (w_q.size() > 0) begin
            wexp = w_q.pop_front();
            chk("wdata", bus.m_axi_wdata, wexp[BUS_W-1:0]);
            chk("wlast", bus.m_axi_wlast, wexp[BUS_W]);
          end
          wbeats++;
          if (wbeats == BEATS) wdone = 1;
        end
        wr_t++;
      end else bus.m_axi_wready = 1'b0;
      tick();
    end
    idle_inputs();
    chk("completed_in_budget", done, 1);
    chk("pulse_one_cycle", bus.mem_data_valid, 0);
    chk("pulse_count", mdv, 1);
    chk("back_to_idle", {bus.m_axi_arvalid, bus.m_axi_awvalid}, 0);
    chk("ar_handshakes", ar_hs, v.wr ? 0 : 1);
    chk("aw_handshakes", aw_hs, v.wr ? 1 : 0);
    chk("w_beats", wbeats, v.wr ? BEATS : 0);
    if (v.wr) chk("w_before_aw", wviol, 0);
    chk("scoreboard_drained", rd_q.size() + w_q.size(), 0);
    rd_q.delete();
    w_q.delete();
  endtask

  initial begin
    //            wr    addr                    base                    ar_d gap b_d snoop snoop_addr      req2 exp_addr                exp_snoop        lat
    vecs[0] = '{1'b0, 64'h1234,               64'h0,                  0,   0,  0,  -1,   64'h0,          -1,  64'h1200,               64'h0,           10};
    vecs[1] = '{1'b0, 64'h1234,               64'h0,                  3,   1,  0,   8,   64'h7F,         -1,  64'h1200,               64'h40,          20};
    vecs[2] = '{1'b1, 64'h5678,               64'hA0,                 0,   0,  2,  -1,   64'h0,          -1,  64'h5640,               64'h0,           13};
    vecs[3] = '{1'b0, 64'hABCDEF,             64'h100,                0,   0,  0,  -1,   64'h0,           4,  64'hABCDC0,             64'h0,           10};
    vecs[4] = '{1'b1, 64'h2000_0040,          64'h5000,               1,   1,  0,   5,   64'hFFC7,       -1,  64'h2000_0040,          64'hFFC0,        19};
    vecs[5] = '{1'b0, 64'h3FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF8, 0,  0,  0,  10,   64'hDEAD_BEEF,  -1,  64'h3FFF_FFFF_FFFF_FFC0, 64'hDEAD_BEC0,  10};
    vecs[6] = '{1'b0, 64'h4000,               64'h700,                0,   0,  0,  -1,   64'h0,          -1,  64'h4000,               64'h0,           10};

    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    chk_all_zero("in_reset");
    #2 rst = 1'b1;
    tick();
    chk_all_zero("after_reset");
    chk("ac_ready_tied", bus.ac_ready, 1);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Back-to-back snoops give back-to-back pulses
    bus.ac_valid = 1'b1;
    bus.ac_addr  = 64'h1_0000_007F;
    tick();
    chk("b2b_snoop0_pulse", bus.invalidate_cache, 1);
    chk("b2b_snoop0_addr", bus.invalidate_cache_addr, 64'h1_0000_0040);
    bus.ac_addr = 64'h2345;
    tick();
    chk("b2b_snoop1_pulse", bus.invalidate_cache, 1);
    chk("b2b_snoop1_addr", bus.invalidate_cache_addr, 64'h2340);
    bus.ac_valid = 1'b0;
    bus.ac_addr  = '0;
    tick();
    chk("b2b_snoop_end", bus.invalidate_cache, 0);

    // Reset in the middle of a read burst, after four beats
    bus.mem_req     = 1'b1;
    bus.mem_address = 64'h4000;
    tick();
    bus.mem_req     = 1'b0;
    bus.mem_address = '0;
    bus.m_axi_arready = 1'b1;
    tick();
    bus.m_axi_arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rdata  = 64'hF00 + 64'(i);
      tick();
    end
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata  = '0;
    chk("mid_burst_rready", bus.m_axi_rready, 1);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    last_read = '0;
    tick();
    tick();
    #2 rst = 1'b1;
    tick();
    run_txn(vecs[6]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
